// File: rtl/sync_fifo_if.sv
// Handshake bundle between a FIFO and the logic that fills and drains it.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_write;
    logic                  write;
    logic                  full;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] data_read;
    logic                  next_read;
    logic                  empty;

    modport master (
        output data_write,
        output write,
        output next_read,
        input  full,
        input  almost_full,
        input  data_read,
        input  empty
    );

    modport slave (
        input  data_write,
        input  write,
        input  next_read,
        output full,
        output almost_full,
        output data_read,
        output empty
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// The head word is driven combinationally from storage. Status flags decode
// only from the registered occupancy count, so they never depend on this
// cycle's write/next_read.
module sync_fifo #(
    parameter int NUM_SLOTS     = 4,
    parameter int LOG_NUM_SLOTS = 2,
    parameter int DATA_WIDTH    = 32
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus_io
);

    localparam logic [LOG_NUM_SLOTS-1:0] PTR_LAST   = (LOG_NUM_SLOTS)'(NUM_SLOTS - 1);
    localparam logic [LOG_NUM_SLOTS-1:0] PTR_ONE    = (LOG_NUM_SLOTS)'(1);
    localparam logic [LOG_NUM_SLOTS:0]   CNT_ONE    = (LOG_NUM_SLOTS + 1)'(1);
    localparam logic [LOG_NUM_SLOTS:0]   CNT_FULL   = (LOG_NUM_SLOTS + 1)'(NUM_SLOTS);
    localparam logic [LOG_NUM_SLOTS:0]   CNT_AFULL  = (LOG_NUM_SLOTS + 1)'(NUM_SLOTS - 1);

    logic [DATA_WIDTH-1:0]    mem_q [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_NUM_SLOTS-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_NUM_SLOTS:0]   count_q,  count_d;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;

    // Pointers wrap by explicit compare so NUM_SLOTS need not be a power of two.
    function automatic logic [LOG_NUM_SLOTS-1:0] ptr_inc(input logic [LOG_NUM_SLOTS-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_ONE;
    endfunction

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // Acceptance uses start-of-cycle flags: a write while full is dropped even
    // if a read frees a slot this cycle, and a read while empty is ignored even
    // if a word is written this cycle (no same-cycle bypass).
    assign wr_acc = bus_io.write     & ~full_w;
    assign rd_acc = bus_io.next_read & ~empty_w;

    assign bus_io.full        = full_w;
    assign bus_io.empty       = empty_w;
    assign bus_io.almost_full = (count_q >= CNT_AFULL);
    assign bus_io.data_read   = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the FIFO immediately and restarts at slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale words are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus_io.data_write;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based model of FIFO contents,
// directed scenarios for the documented corner cases, then random traffic.
module tb_sync_fifo;
    localparam int N    = 4;
    localparam int LOGN = 2;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst;

    sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    sync_fifo #(
        .NUM_SLOTS    (N),
        .LOG_NUM_SLOTS(LOGN),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: words the FIFO should hold, occupancy after the last issued
    // cycle, and occupancy during the cycle currently on the inputs.
    logic [DW-1:0] exp_q[$];
    int occ     = 0;
    int exp_occ = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Issue one cycle of stimulus (called at posedge+1, returns at next posedge+1).
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        bus.write      = w;
        bus.data_write = d;
        bus.next_read  = r;
        exp_occ = occ;
        if (w && exp_occ < N) begin
            exp_q.push_back(d);
            occ++;
        end
        if (r && exp_occ > 0) begin
            occ--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.write      = 1'b0;
        bus.next_read  = 1'b0;
        bus.data_write = '0;
        rst = 1'b1;
        #1;
        exp_q.delete();
        occ     = 0;
        exp_occ = 0;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_almost_full", bus.almost_full, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: flags every cycle, head word whenever the model holds data;
    // the head is retired when the model says the read is accepted.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                chk("empty", bus.empty, exp_occ == 0);
                chk("full", bus.full, exp_occ == N);
                chk("almost_full", bus.almost_full, exp_occ >= N - 1);
                if (exp_occ > 0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard_underflow: model occupancy %0d with no queued word", exp_occ);
                    end else begin
                        chk("data_read", bus.data_read, exp_q[0]);
                        if (bus.next_read) begin
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        do_reset();

        // Reads on an empty FIFO change nothing.
        repeat (3) cycle(1'b0, '0, 1'b1);
        chk("empty_after_idle_reads", bus.empty, 1);

        // Fill; fifth write is dropped.
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 32'hA0 + i, 1'b0);
            if (i == 2) begin
                chk("af_after_3", bus.almost_full, 1);
                chk("full_after_3", bus.full, 0);
            end
        end
        chk("full_after_4", bus.full, 1);
        cycle(1'b1, 32'hA4, 1'b0);
        chk("full_after_drop", bus.full, 1);

        // Drain in order; A4 must not appear.
        repeat (4) cycle(1'b0, '0, 1'b1);
        chk("empty_after_drain", bus.empty, 1);
        repeat (2) cycle(1'b0, '0, 1'b1);

        // Streaming with one word preloaded; pointers wrap.
        cycle(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h101 + i, 1'b1);
        end
        chk("stream_not_empty", bus.empty, 0);
        chk("stream_not_af", bus.almost_full, 0);
        cycle(1'b0, '0, 1'b1);

        // Write while full with read: read proceeds, write lost.
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 32'hB0 + i, 1'b0);
        end
        cycle(1'b1, 32'hBF, 1'b1);
        chk("wfull_read_full", bus.full, 0);
        chk("wfull_read_af", bus.almost_full, 1);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // Write into empty with read: word retained.
        cycle(1'b1, 32'hC0, 1'b1);
        chk("wempty_read_kept", bus.empty, 0);
        chk("wempty_read_data", bus.data_read, 32'hC0);
        cycle(1'b0, '0, 1'b1);

        // Reset mid-operation with 3 words stored.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hD0 + i, 1'b0);
        end
        do_reset();
        cycle(1'b1, 32'h55, 1'b0);
        chk("post_reset_data", bus.data_read, 32'h55);
        chk("post_reset_empty", bus.empty, 0);
        cycle(1'b0, '0, 1'b1);

        // Random traffic: write-heavy, then read-heavy, then balanced.
        repeat (300) cycle($urandom_range(0, 99) < 75, $urandom, $urandom_range(0, 99) < 35);
        repeat (300) cycle($urandom_range(0, 99) < 35, $urandom, $urandom_range(0, 99) < 75);
        repeat (300) cycle($urandom_range(0, 99) < 50, $urandom, $urandom_range(0, 99) < 50);

        repeat (N + 1) cycle(1'b0, '0, 1'b1);
        chk("final_empty", bus.empty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
